// File: rtl/digit_scan_pkg.sv
// Shared types and pin-polarity constants for the multiplexed 7-segment scan controller.
package digit_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_GUARD = 2'd2
   } scan_state_e;

   localparam int unsigned MAX_DIGITS = 8;

   // Common-anode digits: a one on an anode line means the digit is off.
   localparam logic [MAX_DIGITS-1:0] DIG_OFF  = '1;
   localparam logic [3:0]            BCD_ZERO = 4'h0;

   localparam logic LT_ACTIVE  = 1'b0;
   localparam logic LT_IDLE    = 1'b1;
   localparam logic RBI_ACTIVE = 1'b0;
   localparam logic RBI_IDLE   = 1'b1;
   localparam logic BI_BLANK   = 1'b0;
   localparam logic BI_IDLE    = 1'b1;

endpackage

// File: rtl/digit_scan_ctrl_timer.sv
// Loadable down-counter timing one DRIVE or GUARD slot; flags the final cycle and the one before it.
module scan_slot_timer #(
   parameter int unsigned LEN_W = 3,
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             last_c_o,
   output logic             next_last_c_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load length-1 so the slot spans exactly len_i cycles; hold at zero afterwards.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(len_i - LEN_W'(1));
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_c_o      = (cnt_q == '0);
   assign next_last_c_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits MSD-first through one shared BCD-to-7-segment decoder,
// with per-slot dwell, all-off guard gaps, leading-zero blanking and a double-buffered value.
module digit_scan_ctrl
   import digit_scan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned PRESCALE   = 1000,
   parameter int unsigned GUARD      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic                    blank_lz_i,
   input  logic                    lamp_test_i,
   output logic [3:0]              dig_code_o,
   output logic                    dec_lt_o,
   output logic                    dec_rbi_o,
   output logic                    dec_bi_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_done_o
);

   localparam int unsigned MAX_LEN = (PRESCALE > GUARD) ? PRESCALE : GUARD;
   localparam int unsigned CNT_W   = $clog2(MAX_LEN);
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = NUM_DIGITS'(DIG_OFF);
   localparam logic                  GUARD_ONE = (GUARD == 1);

   scan_state_e             state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    zero_run_q, zero_run_d;
   logic [VAL_W-1:0]        shadow_q, shadow_d;
   logic [VAL_W-1:0]        pending_q, pending_d;
   logic                    pend_q, pend_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [3:0]              dig_code_q, dig_code_d;
   logic                    dec_lt_q, dec_lt_d;
   logic                    dec_rbi_q, dec_rbi_d;
   logic                    dec_bi_q, dec_bi_d;
   logic                    frame_done_q, frame_done_d;

   logic                    tmr_load;
   logic [LEN_W-1:0]        tmr_len;
   logic                    tmr_last;
   logic                    tmr_next_last;
   logic                    enter_drive;
   logic [IDX_W-1:0]        new_idx;
   logic                    new_zr;
   logic [3:0]              nib;
   logic                    blank;

   scan_slot_timer #(
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .load_i        (tmr_load),
      .len_i         (tmr_len),
      .last_c_o      (tmr_last),
      .next_last_c_o (tmr_next_last)
   );

   // Next state and next registered outputs; slot outputs are decided once at DRIVE entry.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      zero_run_d   = zero_run_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      pend_d       = pend_q;
      an_d         = an_q;
      dig_code_d   = dig_code_q;
      dec_lt_d     = dec_lt_q;
      dec_rbi_d    = dec_rbi_q;
      dec_bi_d     = dec_bi_q;
      frame_done_d = 1'b0;
      tmr_load     = 1'b0;
      tmr_len      = LEN_W'(PRESCALE);
      enter_drive  = 1'b0;
      new_idx      = idx_q;
      new_zr       = zero_run_q;
      nib          = BCD_ZERO;
      blank        = 1'b0;

      if (load_i) begin
         pending_d = value_i;
         pend_d    = 1'b1;
      end

      if (!en_i) begin
         state_d    = S_IDLE;
         an_d       = AN_OFF;
         dig_code_d = BCD_ZERO;
         dec_lt_d   = LT_IDLE;
         dec_rbi_d  = RBI_IDLE;
         dec_bi_d   = BI_BLANK;
      end else begin
         case (state_q)
            S_IDLE: begin
               enter_drive = 1'b1;
               new_idx     = IDX_LAST;
               new_zr      = blank_lz_i;
            end
            S_DRIVE: begin
               if (tmr_last) begin
                  state_d      = S_GUARD;
                  tmr_load     = 1'b1;
                  tmr_len      = LEN_W'(GUARD);
                  an_d         = AN_OFF;
                  dec_bi_d     = BI_BLANK;
                  frame_done_d = GUARD_ONE && (idx_q == '0);
               end
            end
            S_GUARD: begin
               // frame_done is registered, so it is raised one cycle ahead of the last LSD guard cycle.
               frame_done_d = tmr_next_last && (idx_q == '0);
               if (tmr_last) begin
                  enter_drive = 1'b1;
                  if (idx_q != '0) begin
                     new_idx = idx_q - IDX_W'(1);
                  end else begin
                     new_idx = IDX_LAST;
                     new_zr  = blank_lz_i;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (enter_drive) begin
         state_d  = S_DRIVE;
         tmr_load = 1'b1;
         tmr_len  = LEN_W'(PRESCALE);
         idx_d    = new_idx;
         // Frame start swaps in the latest value; a load in this very cycle takes priority.
         if (new_idx == IDX_LAST) begin
            if (load_i) begin
               shadow_d = value_i;
               pend_d   = 1'b0;
            end else if (pend_q) begin
               shadow_d = pending_q;
               pend_d   = 1'b0;
            end
         end
         nib        = 4'(shadow_d >> {new_idx, 2'b00});
         blank      = new_zr && (nib == BCD_ZERO) && (new_idx != '0) && !lamp_test_i;
         zero_run_d = blank;
         dig_code_d = nib;
         dec_lt_d   = lamp_test_i ? LT_ACTIVE : LT_IDLE;
         if (blank) begin
            an_d      = AN_OFF;
            dec_rbi_d = RBI_ACTIVE;
            dec_bi_d  = BI_BLANK;
         end else begin
            an_d      = AN_OFF & ~(NUM_DIGITS'(1) << new_idx);
            dec_rbi_d = RBI_IDLE;
            dec_bi_d  = BI_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         zero_run_q   <= 1'b0;
         shadow_q     <= '0;
         pending_q    <= '0;
         pend_q       <= 1'b0;
         an_q         <= AN_OFF;
         dig_code_q   <= BCD_ZERO;
         dec_lt_q     <= LT_IDLE;
         dec_rbi_q    <= RBI_IDLE;
         dec_bi_q     <= BI_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         zero_run_q   <= zero_run_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         pend_q       <= pend_d;
         an_q         <= an_d;
         dig_code_q   <= dig_code_d;
         dec_lt_q     <= dec_lt_d;
         dec_rbi_q    <= dec_rbi_d;
         dec_bi_q     <= dec_bi_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an_o         = an_q;
   assign dig_code_o   = dig_code_q;
   assign dec_lt_o     = dec_lt_q;
   assign dec_rbi_o    = dec_rbi_q;
   assign dec_bi_o     = dec_bi_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl (4 digits, 4-cycle dwell, 1-cycle guard) against a
// frame-level model of what each slot should show.
module tb_digit_scan_ctrl;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] value;
   logic        blank_lz;
   logic        lamp_test;
   logic [3:0]  dig_code;
   logic        dec_lt;
   logic        dec_rbi;
   logic        dec_bi;
   logic [3:0]  an;
   logic        frame_done;

   int          n_checks;
   int          n_errors;

   // Reference state: value on display, buffered value, and inputs seen at the last clock edge.
   logic [15:0] m_shadow;
   logic [15:0] m_pending;
   bit          m_pend;
   bit          e_blz;
   bit          e_lt;

   digit_scan_ctrl #(
      .NUM_DIGITS (4),
      .PRESCALE   (4),
      .GUARD      (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en),
      .load_i       (load),
      .value_i      (value),
      .blank_lz_i   (blank_lz),
      .lamp_test_i  (lamp_test),
      .dig_code_o   (dig_code),
      .dec_lt_o     (dec_lt),
      .dec_rbi_o    (dec_rbi),
      .dec_bi_o     (dec_bi),
      .an_o         (an),
      .frame_done_o (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: record what the DUT samples at this edge, then step to just after it.
   task automatic tick();
      e_blz = blank_lz;
      e_lt  = lamp_test;
      if (rst) begin
         m_shadow  = '0;
         m_pending = '0;
         m_pend    = 1'b0;
      end else if (load) begin
         m_pending = value;
         m_pend    = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_off(input string tag);
      chk({tag, ".an"},   16'(an),         16'hF);
      chk({tag, ".code"}, 16'(dig_code),   16'h0);
      chk({tag, ".lt"},   16'(dec_lt),     16'h1);
      chk({tag, ".rbi"},  16'(dec_rbi),    16'h1);
      chk({tag, ".bi"},   16'(dec_bi),     16'h0);
      chk({tag, ".fd"},   16'(frame_done), 16'h0);
   endtask

   // Walk a frame whose first DRIVE cycle is current, for n_cyc cycles (20 = whole frame),
   // optionally pulsing load at frame-relative cycles l1 and l2.
   task automatic run_frame(input int n_cyc, input int l1, input logic [15:0] v1,
                            input int l2, input logic [15:0] v2);
      int          k;
      bit          zr;
      bit          blank;
      bit          slot_lt;
      logic [3:0]  nib;
      logic [3:0]  exp_an;
      k  = 0;
      zr = 1'b0;
      for (int d = 3; d >= 0; d--) begin
         if (d == 3) begin
            if (m_pend) begin
               m_shadow = m_pending;
               m_pend   = 1'b0;
            end
            zr = e_blz;
         end
         nib     = m_shadow[d*4 +: 4];
         slot_lt = e_lt;
         blank   = zr && (nib == 4'h0) && (d != 0) && !slot_lt;
         if (!blank) zr = 1'b0;
         exp_an  = blank ? 4'hF : (4'hF ^ (4'b1 << d));
         for (int c = 0; c < 4; c++) begin
            if (k >= n_cyc) return;
            chk($sformatf("drv%0d.an", d),   16'(an),         16'(exp_an));
            chk($sformatf("drv%0d.code", d), 16'(dig_code),   16'(nib));
            chk($sformatf("drv%0d.lt", d),   16'(dec_lt),     16'(!slot_lt));
            chk($sformatf("drv%0d.rbi", d),  16'(dec_rbi),    16'(!blank));
            chk($sformatf("drv%0d.bi", d),   16'(dec_bi),     16'(!blank));
            chk($sformatf("drv%0d.fd", d),   16'(frame_done), 16'h0);
            load  = (k == l1) || (k == l2);
            value = (k == l2) ? v2 : ((k == l1) ? v1 : value);
            tick();
            k++;
         end
         if (k >= n_cyc) return;
         chk($sformatf("grd%0d.an", d), 16'(an),         16'hF);
         chk($sformatf("grd%0d.bi", d), 16'(dec_bi),     16'h0);
         chk($sformatf("grd%0d.fd", d), 16'(frame_done), 16'(d == 0));
         load  = (k == l1) || (k == l2);
         value = (k == l2) ? v2 : ((k == l1) ? v1 : value);
         tick();
         k++;
      end
      load = 1'b0;
   endtask

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) begin
         v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   initial begin
      int          r1;
      int          r2;
      logic [15:0] rv1;
      logic [15:0] rv2;
      n_checks  = 0;
      n_errors  = 0;
      m_shadow  = '0;
      m_pending = '0;
      m_pend    = 1'b0;
      e_blz     = 1'b0;
      e_lt      = 1'b0;
      rst       = 1'b1;
      en        = 1'b0;
      load      = 1'b0;
      value     = '0;
      blank_lz  = 1'b0;
      lamp_test = 1'b0;
      tick();
      tick();
      chk_off("reset");

      // Plain scan of 1234, two frames back to back.
      rst   = 1'b0;
      en    = 1'b1;
      load  = 1'b1;
      value = 16'h1234;
      tick();
      load  = 1'b0;
      run_frame(20, -1, '0, -1, '0);
      run_frame(20, -1, '0, -1, '0);

      // Leading-zero suppression of 0070, then an all-zero value loaded on the frame boundary.
      blank_lz = 1'b1;
      run_frame(20, 5, 16'h0070, -1, '0);
      run_frame(20, -1, '0, -1, '0);
      run_frame(20, 19, 16'h0000, -1, '0);
      run_frame(20, -1, '0, -1, '0);

      // Mid-frame loads land on the next frame, latest load wins.
      blank_lz = 1'b0;
      run_frame(20, 19, 16'h1234, -1, '0);
      run_frame(20, 6, 16'h5678, 12, 16'h9999);
      run_frame(20, -1, '0, -1, '0);

      // Lamp test over a zero value with blanking on, then release.
      blank_lz  = 1'b1;
      lamp_test = 1'b1;
      run_frame(20, 19, 16'h0000, -1, '0);
      run_frame(20, -1, '0, -1, '0);
      lamp_test = 1'b0;
      run_frame(20, -1, '0, -1, '0);
      run_frame(20, -1, '0, -1, '0);

      // Reset in the middle of a DRIVE slot.
      run_frame(20, 19, 16'h0305, -1, '0);
      run_frame(6, -1, '0, -1, '0);
      rst = 1'b1;
      tick();
      chk_off("midrst");
      rst = 1'b0;
      tick();
      run_frame(20, -1, '0, -1, '0);

      // Disable mid-frame, load while idle, re-enable restarts at the MSD.
      run_frame(20, 19, 16'h1234, -1, '0);
      run_frame(7, -1, '0, -1, '0);
      en = 1'b0;
      tick();
      chk_off("idle0");
      load  = 1'b1;
      value = 16'h4321;
      tick();
      load  = 1'b0;
      chk_off("idle1");
      tick();
      chk_off("idle2");
      en = 1'b1;
      tick();
      run_frame(20, -1, '0, -1, '0);

      // Randomized frames: values, loads, blanking and lamp test.
      for (int f = 0; f < 40; f++) begin
         blank_lz  = 1'($urandom_range(0, 1));
         lamp_test = ($urandom_range(0, 3) == 0);
         r1  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 19));
         r2  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : -1;
         rv1 = rand_val();
         rv2 = rand_val();
         run_frame(20, r1, rv1, r2, rv2);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
